tpg_multi: RTL and testbench

Parametrised video test pattern generator, successor to the single-ramp `tpg`. It produces hsync, vsync and data-enable from runtime timing inputs, plus one of four selectable pixel patterns: gray ramp, colour bars, checkerboard and solid colour. It also provides programmable sync polarity, start/stop at frame boundaries, start-of-frame/end-of-line markers and a frame counter. It sits at the head of the video pipeline and drives the downstream pixel interface directly.

---
 rtl/tpg_pkg.sv | 24 ++
 rtl/tpg_timing.sv | 99 +++++++++
 rtl/tpg_multi.sv | 144 ++++++++++++++
 tb/tb_tpg_multi.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpg_pkg.sv
// Shared types and constants for the multi-pattern video test pattern generator.
package tpg_pkg;

    typedef enum logic [1:0] {
        MODE_RAMP  = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_SOLID = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // {R,G,B} on/off per bar index: the index is inverted, so bar 0 is white and bar 7 black.
    localparam logic [7:0][2:0] BAR_TABLE = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

    function automatic logic [2:0] bar_sat_inc(input logic [2:0] b);
        return (b == 3'd7) ? 3'd7 : b + 3'd1;
    endfunction

endpackage

// File: rtl/tpg_timing.sv
// Run/drain/idle control, raster counters, raw sync and active-area decode, frame counter.
module tpg_timing
    import tpg_pkg::*;
#(
    parameter int H_BITS  = 12,
    parameter int V_BITS  = 12,
    parameter int FC_BITS = 16
)(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    input  logic [H_BITS-1:0] ths_start_i,
    input  logic [H_BITS-1:0] ths_end_i,
    input  logic [H_BITS-1:0] thact_start_i,
    input  logic [H_BITS-1:0] thact_end_i,
    input  logic [H_BITS-1:0] th_end_i,
    input  logic [V_BITS-1:0] tvs_start_i,
    input  logic [V_BITS-1:0] tvs_end_i,
    input  logic [V_BITS-1:0] tvact_start_i,
    input  logic [V_BITS-1:0] tvact_end_i,
    input  logic [V_BITS-1:0] tv_end_i,
    output logic              run_o,
    output logic              start_o,
    output logic              hs_raw_o,
    output logic              vs_raw_o,
    output logic              de_o,
    output logic              sof_o,
    output logic              eol_o,
    output logic [H_BITS-1:0] x_o,
    output logic [V_BITS-1:0] y_o,
    output logic [FC_BITS-1:0] frame_cnt_o
);

    state_e             state_q;
    logic [H_BITS-1:0]  x_q;
    logic [V_BITS-1:0]  y_q;
    logic [FC_BITS-1:0] fc_q;
    logic               line_end_s;
    logic               frame_end_s;

    assign line_end_s  = (x_q == th_end_i - H_BITS'(1));
    assign frame_end_s = line_end_s && (y_q == tv_end_i - V_BITS'(1));

    // Mode FSM and raster counters; a stop request only takes effect at the frame boundary.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            x_q     <= {H_BITS{1'b0}};
            y_q     <= {V_BITS{1'b0}};
            fc_q    <= {FC_BITS{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    x_q <= {H_BITS{1'b0}};
                    y_q <= {V_BITS{1'b0}};
                    if (en_i) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    if (line_end_s) begin
                        x_q <= {H_BITS{1'b0}};
                        if (frame_end_s) begin
                            y_q  <= {V_BITS{1'b0}};
                            fc_q <= fc_q + FC_BITS'(1);
                        end else begin
                            y_q <= y_q + V_BITS'(1);
                        end
                    end else begin
                        x_q <= x_q + H_BITS'(1);
                    end
                    if (frame_end_s) begin
                        state_q <= en_i ? ST_RUN : ST_IDLE;
                    end else if (!en_i) begin
                        state_q <= ST_DRAIN;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    x_q     <= {H_BITS{1'b0}};
                    y_q     <= {V_BITS{1'b0}};
                end
            endcase
        end
    end

    assign run_o       = (state_q != ST_IDLE);
    assign start_o     = (state_q == ST_IDLE) && en_i;
    assign x_o         = x_q;
    assign y_o         = y_q;
    assign frame_cnt_o = fc_q;
    assign hs_raw_o    = run_o && (x_q >= ths_start_i) && (x_q < ths_end_i);
    assign vs_raw_o    = run_o && (y_q >= tvs_start_i) && (y_q < tvs_end_i);
    assign de_o        = run_o && (x_q >= thact_start_i) && (x_q < thact_end_i)
                               && (y_q >= tvact_start_i) && (y_q < tvact_end_i);
    assign sof_o       = de_o && (x_q == thact_start_i) && (y_q == tvact_start_i);
    assign eol_o       = de_o && (x_q == thact_end_i - H_BITS'(1));

endmodule

// File: rtl/tpg_multi.sv
// Test pattern generator top: pattern selection, per-frame settings capture and output registers.
module tpg_multi
    import tpg_pkg::*;
#(
    parameter int PW       = 8,
    parameter int H_BITS   = 12,
    parameter int V_BITS   = 12,
    parameter int CHK_LOG2 = 3,
    parameter int FC_BITS  = 16
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic                hs_pol,
    input  logic                vs_pol,
    input  logic [3*PW-1:0]     solid_rgb,
    input  logic [H_BITS-1:0]   tBAR_W,
    input  logic [H_BITS-1:0]   tHS_START,
    input  logic [H_BITS-1:0]   tHS_END,
    input  logic [H_BITS-1:0]   tHACT_START,
    input  logic [H_BITS-1:0]   tHACT_END,
    input  logic [H_BITS-1:0]   tH_END,
    input  logic [V_BITS-1:0]   tVS_START,
    input  logic [V_BITS-1:0]   tVS_END,
    input  logic [V_BITS-1:0]   tVACT_START,
    input  logic [V_BITS-1:0]   tVACT_END,
    input  logic [V_BITS-1:0]   tV_END,
    output logic                hs_q,
    output logic                vs_q,
    output logic                vld_q,
    output logic                sof_q,
    output logic                eol_q,
    output logic [3*PW-1:0]     rgb_q,
    output logic [FC_BITS-1:0]  frame_cnt_q
);

    logic              run_s, start_s, hs_raw_s, vs_raw_s, de_s, sof_s, eol_s, take_cfg_s;
    logic [H_BITS-1:0] x_s;
    logic [V_BITS-1:0] y_s;
    mode_e             mode_q, mode_s;
    logic              hs_pol_q, vs_pol_q, hs_pol_s, vs_pol_s;
    logic [3*PW-1:0]   solid_q, solid_s, pix_s;
    logic [H_BITS-1:0] bar_w_q, bar_w_s, cnt_q, cnt_cur_s, cnt_d;
    logic [2:0]        bar_q, bar_cur_s, bar_d, bar_rgb_s;
    logic [PW-1:0]     ramp_s;
    logic              chk_s;

    tpg_timing #(.H_BITS(H_BITS), .V_BITS(V_BITS), .FC_BITS(FC_BITS)) u_timing (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en),
        .ths_start_i(tHS_START), .ths_end_i(tHS_END),
        .thact_start_i(tHACT_START), .thact_end_i(tHACT_END), .th_end_i(tH_END),
        .tvs_start_i(tVS_START), .tvs_end_i(tVS_END),
        .tvact_start_i(tVACT_START), .tvact_end_i(tVACT_END), .tv_end_i(tV_END),
        .run_o(run_s), .start_o(start_s), .hs_raw_o(hs_raw_s), .vs_raw_o(vs_raw_s),
        .de_o(de_s), .sof_o(sof_s), .eol_o(eol_s), .x_o(x_s), .y_o(y_s),
        .frame_cnt_o(frame_cnt_q)
    );

    // Live inputs steer the origin cycle itself so the whole frame, pixel (0,0) included, sees one setting.
    assign take_cfg_s = start_s || (run_s && (x_s == {H_BITS{1'b0}}) && (y_s == {V_BITS{1'b0}}));
    assign mode_s     = take_cfg_s ? mode_e'(mode) : mode_q;
    assign hs_pol_s   = take_cfg_s ? hs_pol : hs_pol_q;
    assign vs_pol_s   = take_cfg_s ? vs_pol : vs_pol_q;
    assign solid_s    = take_cfg_s ? solid_rgb : solid_q;
    assign bar_w_s    = take_cfg_s ? tBAR_W : bar_w_q;

    assign ramp_s    = PW'(x_s - tHACT_START) + PW'(y_s - tVACT_START);
    assign chk_s     = 1'((x_s - tHACT_START) >> CHK_LOG2) ^ 1'((y_s - tVACT_START) >> CHK_LOG2);
    assign bar_rgb_s = BAR_TABLE[bar_cur_s];

    // Bar tracking: restart at the first active pixel of each line, advance every bar_w pixels.
    always_comb begin
        if (x_s == tHACT_START) begin
            bar_cur_s = 3'd0;
            cnt_cur_s = {H_BITS{1'b0}};
        end else begin
            bar_cur_s = bar_q;
            cnt_cur_s = cnt_q;
        end
        if (cnt_cur_s + H_BITS'(1) == bar_w_s) begin
            cnt_d = {H_BITS{1'b0}};
            bar_d = bar_sat_inc(bar_cur_s);
        end else begin
            cnt_d = cnt_cur_s + H_BITS'(1);
            bar_d = bar_cur_s;
        end
    end

    // Pattern multiplexer.
    always_comb begin
        pix_s = {(3*PW){1'b0}};
        case (mode_s)
            MODE_RAMP:  pix_s = {3{ramp_s}};
            MODE_BARS:  pix_s = {{PW{bar_rgb_s[2]}}, {PW{bar_rgb_s[1]}}, {PW{bar_rgb_s[0]}}};
            MODE_CHECK: pix_s = {(3*PW){chk_s}};
            MODE_SOLID: pix_s = solid_s;
            default:    pix_s = {(3*PW){1'b0}};
        endcase
    end

    // Per-frame settings capture and bar tracker state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q   <= MODE_RAMP;
            hs_pol_q <= 1'b1;
            vs_pol_q <= 1'b1;
            solid_q  <= {(3*PW){1'b0}};
            bar_w_q  <= H_BITS'(1);
            bar_q    <= 3'd0;
            cnt_q    <= {H_BITS{1'b0}};
        end else begin
            mode_q   <= mode_s;
            hs_pol_q <= hs_pol_s;
            vs_pol_q <= vs_pol_s;
            solid_q  <= solid_s;
            bar_w_q  <= bar_w_s;
            if (de_s) begin
                bar_q <= bar_d;
                cnt_q <= cnt_d;
            end
        end
    end

    // Output register stage; idle and blanking force data low and syncs to their inactive level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            vld_q <= 1'b0;
            sof_q <= 1'b0;
            eol_q <= 1'b0;
            rgb_q <= {(3*PW){1'b0}};
        end else begin
            hs_q  <= ~(hs_raw_s ^ hs_pol_s);
            vs_q  <= ~(vs_raw_s ^ vs_pol_s);
            vld_q <= de_s;
            sof_q <= sof_s;
            eol_q <= eol_s;
            rgb_q <= de_s ? pix_s : {(3*PW){1'b0}};
        end
    end

endmodule

// File: tb/tb_tpg_multi.sv
// Self-checking bench for tpg_multi: frame-position reference model, point-check table, corner sequences.
module tb_tpg_multi;

    logic        clk = 1'b0;
    logic        rst_n, en, hs_pol, vs_pol;
    logic [1:0]  mode;
    logic [23:0] solid_rgb;
    logic [11:0] tBAR_W, tHS_START, tHS_END, tHACT_START, tHACT_END, tH_END;
    logic [11:0] tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END;
    logic        hs_q, vs_q, vld_q, sof_q, eol_q;
    logic [23:0] rgb_q;
    logic [15:0] frame_cnt_q;

    int checks = 0;
    int errors = 0;

    // reference model state: frame position as a linear cycle index
    bit m_run;
    int m_pos, m_fc, m_mode, m_solid, m_bw;
    bit m_hp, m_vp;
    bit o_act;
    int ox, oy;

    always #5 clk = ~clk;

    tpg_multi #(.PW(8), .H_BITS(12), .V_BITS(12), .CHK_LOG2(1), .FC_BITS(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .hs_pol(hs_pol), .vs_pol(vs_pol),
        .solid_rgb(solid_rgb), .tBAR_W(tBAR_W),
        .tHS_START(tHS_START), .tHS_END(tHS_END), .tHACT_START(tHACT_START),
        .tHACT_END(tHACT_END), .tH_END(tH_END),
        .tVS_START(tVS_START), .tVS_END(tVS_END), .tVACT_START(tVACT_START),
        .tVACT_END(tVACT_END), .tV_END(tV_END),
        .hs_q(hs_q), .vs_q(vs_q), .vld_q(vld_q), .sof_q(sof_q), .eol_q(eol_q),
        .rgb_q(rgb_q), .frame_cnt_q(frame_cnt_q)
    );

    function automatic int pattern(int md, int xa, int ya, int bw, int solid);
        int b;
        case (md)
            0: return ((xa + ya) % 256) * 'h010101;
            1: begin
                b = xa / bw;
                if (b > 7) b = 7;
                return (((b & 4) != 0) ? 0 : 'hff0000) | (((b & 2) != 0) ? 0 : 'h00ff00)
                     | (((b & 1) != 0) ? 0 : 'h0000ff);
            end
            2: return ((((xa >> 1) ^ (ya >> 1)) & 1) != 0) ? 'hffffff : 0;
            default: return solid;
        endcase
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [44:0] dut_out();
        return {hs_q, vs_q, vld_q, sof_q, eol_q, rgb_q, frame_cnt_q};
    endfunction

    // One clock: predict from the pre-edge model state and inputs, then compare after the edge.
    task automatic step();
        bit e_hs, e_vs, e_de, e_sof, e_eol;
        int e_rgb, x, y, h, v;
        logic [23:0] r24;
        logic [15:0] f16;
        o_act = 1'b0;
        e_hs = 1'b0; e_vs = 1'b0; e_de = 1'b0; e_sof = 1'b0; e_eol = 1'b0; e_rgb = 0;
        h = int'(tH_END);
        v = int'(tV_END);
        if (!rst_n) begin
            m_run = 1'b0; m_pos = 0; m_fc = 0; m_mode = 0; m_solid = 0; m_bw = 1;
            m_hp = 1'b1; m_vp = 1'b1;
        end else begin
            if ((!m_run && en) || (m_run && m_pos == 0)) begin
                m_mode = int'(mode); m_hp = hs_pol; m_vp = vs_pol;
                m_solid = int'(solid_rgb); m_bw = int'(tBAR_W);
            end
            if (!m_run) begin
                e_hs = !m_hp;
                e_vs = !m_vp;
                if (en) begin
                    m_run = 1'b1;
                    m_pos = 0;
                end
            end else begin
                x = m_pos % h;
                y = m_pos / h;
                e_hs = ((x >= int'(tHS_START)) && (x < int'(tHS_END))) ? m_hp : !m_hp;
                e_vs = ((y >= int'(tVS_START)) && (y < int'(tVS_END))) ? m_vp : !m_vp;
                e_de = (x >= int'(tHACT_START)) && (x < int'(tHACT_END))
                    && (y >= int'(tVACT_START)) && (y < int'(tVACT_END));
                e_sof = e_de && (x == int'(tHACT_START)) && (y == int'(tVACT_START));
                e_eol = e_de && (x == int'(tHACT_END) - 1);
                e_rgb = e_de ? pattern(m_mode, x - int'(tHACT_START), y - int'(tVACT_START),
                                       m_bw, m_solid) : 0;
                o_act = 1'b1; ox = x; oy = y;
                if (m_pos == h * v - 1) begin
                    m_fc = (m_fc + 1) % 65536;
                    m_pos = 0;
                    m_run = en;
                end else begin
                    m_pos++;
                end
            end
        end
        r24 = e_rgb[23:0];
        f16 = m_fc[15:0];
        @(posedge clk);
        #1;
        check("model", 64'(dut_out()), 64'({e_hs, e_vs, e_de, e_sof, e_eol, r24, f16}));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic set_t1();
        tH_END = 12'd16; tHS_START = 12'd1; tHS_END = 12'd3; tHACT_START = 12'd4; tHACT_END = 12'd12;
        tV_END = 12'd6;  tVS_START = 12'd0; tVS_END = 12'd1; tVACT_START = 12'd1; tVACT_END = 12'd5;
        tBAR_W = 12'd1;
    endtask

    // Advance until the sampled outputs belong to raster position (tx,ty); bounded.
    task automatic run_to(int tx, int ty);
        bit hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            step();
            hit = o_act && (ox == tx) && (oy == ty);
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL run_to timeout: position (%0d,%0d) not reached", tx, ty);
        end
    endtask

    typedef struct { int md; int x; int y; int rgb; } vec_t;
    vec_t tbl[13];
    logic [44:0] fr1[97];

    initial begin
        int n_sof, n_eol, n_vld, n_hs, n_bad;
        bit hit;
        int a;

        tbl[0]  = '{0, 4, 1, 'h000000};  tbl[1]  = '{0, 7, 2, 'h040404};
        tbl[2]  = '{0, 11, 4, 'h0a0a0a}; tbl[3]  = '{1, 4, 1, 'hffffff};
        tbl[4]  = '{1, 5, 1, 'hffff00};  tbl[5]  = '{1, 6, 2, 'hff00ff};
        tbl[6]  = '{1, 8, 1, 'h00ffff};  tbl[7]  = '{1, 11, 3, 'h000000};
        tbl[8]  = '{2, 4, 1, 'h000000};  tbl[9]  = '{2, 6, 1, 'hffffff};
        tbl[10] = '{2, 4, 3, 'hffffff};  tbl[11] = '{2, 6, 3, 'h000000};
        tbl[12] = '{3, 9, 2, 'h123456};

        rst_n = 1'b0; en = 1'b0; mode = 2'd0; hs_pol = 1'b0; vs_pol = 1'b0;
        solid_rgb = 24'h123456;
        set_t1();

        // reset state, with inverted polarity requested before any run
        do_reset();
        check("reset_state", 64'(dut_out()), 64'd0);

        // table of hand-derived pixel values on T1
        hs_pol = 1'b1; vs_pol = 1'b1;
        for (int i = 0; i < 13; i++) begin
            en = 1'b0;
            do_reset();
            mode = 2'(tbl[i].md);
            en = 1'b1;
            run_to(tbl[i].x, tbl[i].y);
            check($sformatf("table[%0d]", i), 64'({vld_q, rgb_q}), 64'({1'b1, 24'(tbl[i].rgb)}));
        end

        // en held for 3 cycles yields exactly one frame
        en = 1'b0; mode = 2'd0;
        do_reset();
        n_sof = 0; n_eol = 0; n_vld = 0; n_hs = 0;
        en = 1'b1;
        for (int c = 0; c < 115; c++) begin
            if (c == 3) en = 1'b0;
            step();
            n_sof += int'(sof_q); n_eol += int'(eol_q); n_vld += int'(vld_q); n_hs += int'(hs_q);
        end
        check("oneshot_sof", 64'(n_sof), 64'd1);
        check("oneshot_eol", 64'(n_eol), 64'd4);
        check("oneshot_vld", 64'(n_vld), 64'd32);
        check("oneshot_hs", 64'(n_hs), 64'd12);
        check("oneshot_fc_idle", 64'({frame_cnt_q, vld_q}), 64'({16'd1, 1'b0}));

        // inverted polarity: idle level after a frame is high
        hs_pol = 1'b0; vs_pol = 1'b0;
        do_reset();
        en = 1'b1;
        step();
        en = 1'b0;
        for (int c = 0; c < 110; c++) step();
        check("idle_pol_low", 64'({hs_q, vs_q}), 64'd3);
        hs_pol = 1'b1; vs_pol = 1'b1;

        // reset mid line 2, then restart must reproduce the first frame
        do_reset();
        en = 1'b1;
        for (int c = 0; c < 97; c++) begin
            step();
            fr1[c] = dut_out();
        end
        run_to(5, 2);
        rst_n = 1'b0;
        step();
        check("midreset", 64'(dut_out()), 64'd0);
        rst_n = 1'b1;
        n_bad = 0;
        for (int c = 0; c < 97; c++) begin
            step();
            if (dut_out() !== fr1[c]) n_bad++;
        end
        check("restart_frame", 64'(n_bad), 64'd0);

        // randomized timing, settings and en activity against the model
        for (int it = 0; it < 40; it++) begin
            en = 1'b0;
            tH_END = 12'($urandom_range(40, 2));
            a = int'($urandom_range(int'(tH_END), 0)); tHS_START = 12'(a);
            tHS_END = 12'($urandom_range(int'(tH_END), a));
            a = int'($urandom_range(int'(tH_END), 0)); tHACT_START = 12'(a);
            tHACT_END = 12'($urandom_range(int'(tH_END), a));
            tV_END = 12'($urandom_range(8, 1));
            a = int'($urandom_range(int'(tV_END), 0)); tVS_START = 12'(a);
            tVS_END = 12'($urandom_range(int'(tV_END), a));
            a = int'($urandom_range(int'(tV_END), 0)); tVACT_START = 12'(a);
            tVACT_END = 12'($urandom_range(int'(tV_END), a));
            tBAR_W = 12'($urandom_range(5, 1));
            do_reset();
            en = 1'b1;
            for (int c = 0; c < 300; c++) begin
                if ($urandom_range(19, 0) == 0) en = ~en;
                if ($urandom_range(29, 0) == 0) begin
                    mode = 2'($urandom_range(3, 0));
                    hs_pol = 1'($urandom_range(1, 0));
                    vs_pol = 1'($urandom_range(1, 0));
                    solid_rgb = 24'($urandom);
                    tBAR_W = 12'($urandom_range(5, 1));
                end
                step();
            end
        end

        hit = (checks > 0);
        if (!hit) errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
